frame_buffer_reader: RTL

FRAME_BUFFER_READER -- requirements
Module: frame_buffer_reader

---
 rtl/frame_buffer_reader.sv | 126 ++++++++++++
 1 files changed

// File: rtl/frame_buffer_reader.sv
// Frame buffer reader: streams FRAME_PIXELS bytes from a 1-cycle-latency RAM through a 2-entry FIFO.
// Optional feature macro: FRAME_BUFFER_READER_CHECKSUM_EN adds o_Checksum (sum of transferred pixels).
`timescale 1ns/1ps
module frame_buffer_reader #(
  parameter int FRAME_PIXELS = 20000,
  parameter int ADDR_W       = 15
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_Start,
  output logic [ADDR_W-1:0] o_Read_Adress,
  output logic              o_Enable_Read,
  input  logic [7:0]        i_Ram_Data,
  output logic [7:0]        o_Pixel,
  output logic              o_Valid,
  input  logic              i_Ready,
  output logic              o_Last,
  output logic              o_Busy,
  output logic              o_Frame_Done
`ifdef FRAME_BUFFER_READER_CHECKSUM_EN
  ,
  output logic [15:0]       o_Checksum
`endif
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  typedef struct packed {
    logic [7:0] px;
    logic       last;
  } entry_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_PIXELS - 1);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] cnt, addr_q;
  logic              inflight, inflight_last;
  entry_t            fifo [2];
  logic              wr_ptr, rd_ptr;
  logic [1:0]        count;
  logic              push, pop, issue, accept, done;
  logic [2:0]        credit;

  assign push    = inflight;
  assign o_Valid = (count != 2'd0);
  assign pop     = o_Valid && i_Ready;
  assign accept  = (state == IDLE) && i_Start;

  // A pop this cycle frees the slot the next issued read will land in, keeping full throughput.
  assign credit = {1'b0, count} + {2'b00, inflight} - {2'b00, pop};

  always_comb begin
    state_nxt = state;
    issue     = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE:  if (i_Start) state_nxt = RUN;
      RUN: begin
        if (credit < 3'd2) begin
          issue = 1'b1;
          if (cnt == LAST_ADDR) state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (count == 2'd0 && !inflight) begin
          done      = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt           <= '0;
      addr_q        <= '0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
    end else begin
      inflight      <= issue;
      inflight_last <= issue && (cnt == LAST_ADDR);
      if (issue) addr_q <= cnt;
      if (accept) cnt <= '0;
      else if (issue && cnt != LAST_ADDR) cnt <= cnt + 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      fifo[0] <= '0;
      fifo[1] <= '0;
      wr_ptr  <= 1'b0;
      rd_ptr  <= 1'b0;
      count   <= 2'd0;
    end else begin
      if (push) begin
        fifo[wr_ptr] <= '{px: i_Ram_Data, last: inflight_last};
        wr_ptr       <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

`ifdef FRAME_BUFFER_READER_CHECKSUM_EN
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)    o_Checksum <= 16'h0000;
    else if (accept) o_Checksum <= 16'h0000;
    else if (pop)    o_Checksum <= o_Checksum + {8'h00, fifo[rd_ptr].px};
  end
`endif

  assign o_Read_Adress = issue ? cnt : addr_q;
  assign o_Enable_Read = issue;
  assign o_Pixel       = fifo[rd_ptr].px;
  assign o_Last        = o_Valid && fifo[rd_ptr].last;
  assign o_Busy        = (state != IDLE);
  assign o_Frame_Done  = done;

endmodule
